// File: rtl/drive_command_sequencer.sv
// Two-tread H-bridge command sequencer: ramped speed changes, dead-time on reversal, overcurrent latch, watchdog stop.
// Outputs are registered (one edge after acceptance); cmdReady drops while stopping, in dead-time, in fault or on synced overcurrent.
module drive_command_sequencer #(
  parameter int RAMP_DIV   = 4,
  parameter int DEADTIME   = 8,
  parameter int WDT_CYCLES = 100
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic [3:0] cmdDirection,
  input  logic [5:0] cmdSpeed,
  input  logic       overCurrent,
  input  logic       clearFault,
  output logic [3:0] movingDirection,
  output logic [5:0] motorSpeed,
  output logic       fault,
  output logic       cmdError
);

  localparam logic [3:0] DIR_STOP  = 4'b0000;
  localparam logic [3:0] DIR_HARD  = 4'b1111;
  localparam logic [3:0] DIR_FWD   = 4'b0110;
  localparam logic [3:0] DIR_REV   = 4'b1001;
  localparam logic [3:0] DIR_RIGHT = 4'b0101;
  localparam logic [3:0] DIR_LEFT  = 4'b1010;

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam int WW = $clog2(WDT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, RAMP, STOPPING, DEADTIME_WAIT, FAULT} state_t;

  state_t        state, stateNext;
  logic [3:0]    dirReg, dirNext;
  logic [5:0]    spdReg, spdNext;
  logic [5:0]    tgtReg, tgtNext;
  logic [3:0]    pendDir, pendDirNext;
  logic [5:0]    pendTgt, pendTgtNext;
  logic          pendValid, pendValidNext;
  logic [PW-1:0] presc, prescNext;
  logic [DW-1:0] dtCnt, dtNext;
  logic [WW-1:0] wdtCnt, wdtNext;
  logic          cmdErrNext;
  logic          ocMeta, ocSync;

  logic tick, accept, legalMove, dirStopped, wdtExpired, acceptingState;

  function automatic logic [2:0] stepToward(input logic [2:0] cur, input logic [2:0] tgt);
    if (cur < tgt)      return cur + 3'd1;
    else if (cur > tgt) return cur - 3'd1;
    else                return cur;
  endfunction

  assign tick           = (presc == PW'(RAMP_DIV - 1));
  assign acceptingState = (state == IDLE) || (state == RAMP);
  assign cmdReady       = acceptingState && !ocSync;
  assign accept         = cmdValid && cmdReady;
  assign legalMove      = (cmdDirection == DIR_FWD) || (cmdDirection == DIR_REV) ||
                          (cmdDirection == DIR_RIGHT) || (cmdDirection == DIR_LEFT);
  assign dirStopped     = (dirReg == DIR_STOP) || (dirReg == DIR_HARD);
  assign wdtExpired     = (wdtCnt == WW'(WDT_CYCLES));

  assign movingDirection = dirReg;
  assign motorSpeed      = spdReg;
  assign fault           = (state == FAULT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      dirReg    <= DIR_STOP;
      spdReg    <= '0;
      tgtReg    <= '0;
      pendDir   <= DIR_STOP;
      pendTgt   <= '0;
      pendValid <= 1'b0;
      presc     <= '0;
      dtCnt     <= '0;
      wdtCnt    <= '0;
      cmdError  <= 1'b0;
      ocMeta    <= 1'b0;
      ocSync    <= 1'b0;
    end else begin
      state     <= stateNext;
      dirReg    <= dirNext;
      spdReg    <= spdNext;
      tgtReg    <= tgtNext;
      pendDir   <= pendDirNext;
      pendTgt   <= pendTgtNext;
      pendValid <= pendValidNext;
      presc     <= prescNext;
      dtCnt     <= dtNext;
      wdtCnt    <= wdtNext;
      cmdError  <= cmdErrNext;
      ocMeta    <= overCurrent;
      ocSync    <= ocMeta;
    end
  end

  always_comb begin
    stateNext     = state;
    dirNext       = dirReg;
    spdNext       = spdReg;
    tgtNext       = tgtReg;
    pendDirNext   = pendDir;
    pendTgtNext   = pendTgt;
    pendValidNext = pendValid;
    dtNext        = dtCnt;
    cmdErrNext    = 1'b0;
    prescNext     = tick ? '0 : presc + PW'(1);
    // Watchdog only runs while motion is commanded and nothing is arriving.
    wdtNext       = (accept || dirStopped || !acceptingState || wdtExpired) ? '0 : wdtCnt + WW'(1);

    if (ocSync) begin
      stateNext     = FAULT;
      dirNext       = DIR_HARD;
      spdNext       = '0;
      tgtNext       = '0;
      pendValidNext = 1'b0;
    end else begin
      case (state)
        IDLE, RAMP: begin
          if (accept) begin
            if (cmdDirection == DIR_HARD) begin
              stateNext     = IDLE;
              dirNext       = DIR_HARD;
              spdNext       = '0;
              tgtNext       = '0;
              pendValidNext = 1'b0;
            end else if (cmdDirection == DIR_STOP) begin
              stateNext     = STOPPING;
              tgtNext       = '0;
              pendValidNext = 1'b0;
            end else if (!legalMove) begin
              cmdErrNext = 1'b1;
            end else if (cmdDirection == dirReg) begin
              stateNext = RAMP;
              tgtNext   = cmdSpeed;
            end else if (dirStopped) begin
              stateNext = RAMP;
              dirNext   = cmdDirection;
              tgtNext   = cmdSpeed;
            end else begin
              // Reversal/turn change: coast the old direction down first.
              stateNext     = STOPPING;
              tgtNext       = '0;
              pendDirNext   = cmdDirection;
              pendTgtNext   = cmdSpeed;
              pendValidNext = 1'b1;
            end
          end else if (wdtExpired) begin
            stateNext     = STOPPING;
            tgtNext       = '0;
            pendValidNext = 1'b0;
          end else if (state == RAMP) begin
            if (spdReg == tgtReg) begin
              stateNext = IDLE;
            end else if (tick) begin
              spdNext = {stepToward(spdReg[5:3], tgtReg[5:3]), stepToward(spdReg[2:0], tgtReg[2:0])};
            end
          end
        end
        STOPPING: begin
          if (spdReg == 6'd0) begin
            dirNext   = DIR_STOP;
            dtNext    = '0;
            stateNext = pendValid ? DEADTIME_WAIT : IDLE;
          end else if (tick) begin
            spdNext = {stepToward(spdReg[5:3], 3'd0), stepToward(spdReg[2:0], 3'd0)};
          end
        end
        DEADTIME_WAIT: begin
          if (dtCnt == DW'(DEADTIME - 1)) begin
            stateNext     = RAMP;
            dirNext       = pendDir;
            tgtNext       = pendTgt;
            pendValidNext = 1'b0;
          end else begin
            dtNext = dtCnt + DW'(1);
          end
        end
        FAULT: begin
          dirNext = DIR_HARD;
          spdNext = '0;
          if (clearFault) begin
            stateNext = IDLE;
            dirNext   = DIR_STOP;
          end
        end
        default: begin
          stateNext = IDLE;
          dirNext   = DIR_STOP;
          spdNext   = '0;
        end
      endcase
    end
  end

endmodule

// File: doc/drive_command_sequencer.md
DRIVE_COMMAND_SEQUENCER -- requirements
Module: drive_command_sequencer

Interface
REQ-001 Parameter RAMP_DIV, default 4: clock cycles per speed step (prescaler period).
REQ-002 Parameter DEADTIME, default 8: cycles movingDirection is held at 4'b0000 between opposing directions.
REQ-003 Parameter WDT_CYCLES, default 100: cycles without an accepted command before an automatic inertial stop.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  system clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 cmdValid  input  1  command present on cmdDirection/cmdSpeed.
REQ-008 cmdReady  output  1  command accepted on an edge where cmdValid and cmdReady are both 1.
REQ-009 cmdDirection  input  4  requested direction code: 0000 inertial stop, 1111 hard stop, 0110 forward, 1001 reverse, 0101 turn right, 1010 turn left.
REQ-010 cmdSpeed  input  6  target speeds: [2:0] tread 1, [5:3] tread 2.
REQ-011 overCurrent  input  1  asynchronous overcurrent comparator flag.
REQ-012 clearFault  input  1  fault acknowledge.
REQ-013 movingDirection  output  4  direction to the H-bridge stage.
REQ-014 motorSpeed  output  6  current ramped speeds to the H-bridge stage, same packing as cmdSpeed.
REQ-015 fault  output  1  overcurrent latch active.
REQ-016 cmdError  output  1  one-cycle pulse on acceptance of an illegal direction code.

Function
REQ-017 States SHALL be IDLE, RAMP, STOPPING, DEADTIME and FAULT; cmdReady = 1 in IDLE and RAMP only.
REQ-018 A free-running prescaler counting 0..RAMP_DIV-1 SHALL produce a one-cycle tick at RAMP_DIV-1.
REQ-019 In RAMP, on each tick, each tread speed SHALL move 1 toward its target independently, with no wrap beyond 0 or 7; RAMP goes to IDLE when both speeds equal their targets.
REQ-020 An accepted command with the current direction SHALL update the targets on the accepting edge; direction is unchanged.
REQ-021 An accepted non-stop direction in IDLE with both speeds 0 SHALL be visible on movingDirection after the accepting edge, followed by RAMP.
REQ-022 An accepted direction differing from a non-stop current direction SHALL latch the pending command and enter STOPPING.
REQ-023 In STOPPING, the speeds SHALL ramp to 0 with the old direction held, then DEADTIME is entered.
REQ-024 DEADTIME SHALL drive 4'b0000 for exactly DEADTIME cycles, then apply the pending direction and targets and enter RAMP.
REQ-025 An accepted 0000 command SHALL ramp both speeds to 0 with the direction held, then drive 0000 and enter IDLE.
REQ-026 An accepted 1111 command SHALL drive 1111 and 000000 after the accepting edge, bypassing the ramp, clearing any pending command, and entering IDLE.
REQ-027 An illegal direction code SHALL be accepted, pulse cmdError for one cycle, and leave all other state unchanged.
REQ-028 overCurrent SHALL pass through a 2-flop synchronizer; when the synchronized value is 1 in any state, the next edge SHALL enter FAULT with fault=1, movingDirection=1111 and motorSpeed=000000.
REQ-029 FAULT SHALL exit to IDLE, driving 0000 with fault=0, only on an edge with clearFault=1 and synchronized overCurrent=0.
REQ-030 The watchdog counter SHALL clear on each accepted command and whenever the direction is 0000 or 1111.
REQ-031 When the watchdog reaches WDT_CYCLES, the block SHALL behave as an accepted 0000 command.
REQ-032 If overCurrent and cmdValid arrive on the same edge, FAULT SHALL win and the command is not accepted.

Reset
REQ-033 While reset_n=0, outputs SHALL be: movingDirection=0000, motorSpeed=000000, fault=0, cmdError=0, and cmdReady=1 (state IDLE).
REQ-034 The prescaler, watchdog, synchronizer, targets and pending command SHALL all be cleared by reset_n=0.
REQ-035 Reset asserted mid-ramp or mid-DEADTIME SHALL force the reset values immediately, without waiting for a clock edge.

Verification (RAMP_DIV=4, DEADTIME=8, WDT_CYCLES=100)
REQ-036 Reset, then FORWARD with speed 111111: movingDirection=0110 after the accepting edge; each tread counts 0..7, one step per tick, reaching 7/7 within 28-31 cycles.
REQ-037 At FORWARD 7/7, send REVERSE 110110: cmdReady=0; speeds fall to 0 under 0110; then 0000 for exactly 8 cycles; then 1001, ramping to 6/6, with cmdReady=1 from the 1001 edge.
REQ-038 Mid-ramp, send HARD_STOP: next edge gives 1111/000000 and IDLE.
REQ-039 Hold overCurrent high for 3 cycles: fault=1 with 1111/000000 within 3 edges; clearFault while overCurrent is high is ignored; clearFault after it goes low gives 0000 and fault=0.
REQ-040 FORWARD 3/3 with no further commands: after 100 cycles, ramp to 0 then 0000; a direction code of 0011 pulses cmdError for one cycle with outputs unchanged.
